// File: rtl/dram_writer_buf.sv
// dram_writer_buf: buffers a 64-bit input stream in a FIFO and writes one frame
// to DRAM per control handshake as fixed 16-beat AXI3 INCR bursts.
module dram_writer_buf #(
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic        fclk,
  input  logic        rst_n,
  output logic        S2M_AXI_ACLK,
  output logic        S2M_AXI_AWVALID,
  input  logic        S2M_AXI_AWREADY,
  output logic [31:0] S2M_AXI_AWADDR,
  output logic [3:0]  S2M_AXI_AWLEN,
  output logic [1:0]  S2M_AXI_AWSIZE,
  output logic [1:0]  S2M_AXI_AWBURST,
  output logic        S2M_AXI_WVALID,
  input  logic        S2M_AXI_WREADY,
  output logic [63:0] S2M_AXI_WDATA,
  output logic        S2M_AXI_WLAST,
  output logic [7:0]  S2M_AXI_WSTRB,
  input  logic        S2M_AXI_BVALID,
  output logic        S2M_AXI_BREADY,
  input  logic [1:0]  S2M_AXI_BRESP,
  input  logic        wr_frame_valid,
  output logic        wr_frame_ready,
  input  logic [31:0] wr_BUF_ADDR,
  input  logic [31:0] wr_FRAME_BYTES,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din,
  output logic        frame_done,
  output logic        resp_err,
  output logic [1:0]  debug_wstate
);
  localparam int unsigned BURST_BEATS = 16;
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned CW          = AW + 1;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS * 8);
  localparam logic [3:0]  LAST_BEAT   = 4'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  wstate_t       state;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   cur_addr;
  logic [31:0]   end_addr;
  logic [31:0]   next_addr;
  logic [3:0]    beat;
  logic          push;
  logic          pop;
  logic          burst_ready;

  // FIFO occupancy and handshake qualifiers; a burst is only requested once fully buffered
  assign count       = wr_ptr - rd_ptr;
  assign din_ready   = (count != CW'(FIFO_DEPTH));
  assign push        = din_valid && din_ready;
  assign pop         = S2M_AXI_WVALID && S2M_AXI_WREADY;
  assign burst_ready = (count >= CW'(BURST_BEATS));
  assign next_addr   = cur_addr + BURST_BYTES;

  // Fixed burst attributes and show-ahead write data path
  assign S2M_AXI_ACLK    = fclk;
  assign S2M_AXI_AWLEN   = LAST_BEAT;
  assign S2M_AXI_AWSIZE  = 2'b11;
  assign S2M_AXI_AWBURST = 2'b01;
  assign S2M_AXI_WSTRB   = 8'hFF;
  assign S2M_AXI_WVALID  = (state == W_DATA) && (count != '0);
  assign S2M_AXI_WLAST   = (state == W_DATA) && (beat == LAST_BEAT);
  assign S2M_AXI_WDATA   = mem[rd_ptr[AW-1:0]];
  assign debug_wstate    = state;

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge fclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // FIFO pointers; reset flushes the buffer
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Frame/burst sequencer with registered AXI and control outputs
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= W_IDLE;
      S2M_AXI_AWVALID <= 1'b0;
      S2M_AXI_AWADDR  <= '0;
      S2M_AXI_BREADY  <= 1'b0;
      wr_frame_ready  <= 1'b0;
      frame_done      <= 1'b0;
      resp_err        <= 1'b0;
      cur_addr        <= '0;
      end_addr        <= '0;
      beat            <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        W_IDLE: begin
          wr_frame_ready <= 1'b1;
          if (wr_frame_valid && wr_frame_ready) begin
            wr_frame_ready <= 1'b0;
            cur_addr       <= wr_BUF_ADDR;
            end_addr       <= wr_BUF_ADDR + wr_FRAME_BYTES;
            resp_err       <= 1'b0;
            state          <= W_ADDR;
            if (burst_ready) begin
              S2M_AXI_AWVALID <= 1'b1;
              S2M_AXI_AWADDR  <= wr_BUF_ADDR;
            end
          end
        end
        W_ADDR: begin
          if (S2M_AXI_AWVALID) begin
            if (S2M_AXI_AWREADY) begin
              S2M_AXI_AWVALID <= 1'b0;
              beat            <= '0;
              state           <= W_DATA;
            end
          end else if (burst_ready) begin
            S2M_AXI_AWVALID <= 1'b1;
            S2M_AXI_AWADDR  <= cur_addr;
          end
        end
        W_DATA: begin
          if (pop) begin
            beat <= beat + 4'd1;
            if (beat == LAST_BEAT) begin
              S2M_AXI_BREADY <= 1'b1;
              state          <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S2M_AXI_BVALID && S2M_AXI_BREADY) begin
            S2M_AXI_BREADY <= 1'b0;
            resp_err       <= resp_err | (S2M_AXI_BRESP != 2'b00);
            cur_addr       <= next_addr;
            if (next_addr == end_addr) begin
              frame_done     <= 1'b1;
              wr_frame_ready <= 1'b1;
              state          <= W_IDLE;
            end else begin
              state <= W_ADDR;
              if (burst_ready) begin
                S2M_AXI_AWVALID <= 1'b1;
                S2M_AXI_AWADDR  <= next_addr;
              end
            end
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end
endmodule
